// File: rtl/phase_frame_sequencer.sv
// Merges phase streams and one packed tag stream into phase0..phaseN-1, tag frames.
// Optional per-frame length check: define PHASE_SEQ_LEN_CHECK_EN.
module phase_frame_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int TAG_WIDTH    = 8,
    parameter int TAG_CATAGORY = 4,
    parameter int BEAT_SIZE    = 8,
    parameter int FRAME_BEATS  = 512
) (
    input  logic                                         aclk,
    input  logic                                         aresetn,
    input  logic [TAG_CATAGORY*BEAT_SIZE*DATA_WIDTH-1:0] s_phase_tdata,
    input  logic [TAG_CATAGORY-1:0]                      s_phase_tvalid,
    output logic [TAG_CATAGORY-1:0]                      s_phase_tready,
    input  logic [TAG_CATAGORY-1:0]                      s_phase_tlast,
    input  logic [BEAT_SIZE*TAG_WIDTH-1:0]               s_tag_tdata,
    input  logic                                         s_tag_tvalid,
    output logic                                         s_tag_tready,
    input  logic                                         s_tag_tlast,
    output logic [BEAT_SIZE*DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic                                         m_axis_tlast,
    output logic [TAG_CATAGORY:0]                        len_err
);

    localparam int PACK           = DATA_WIDTH / TAG_WIDTH;
    localparam int TAG_PART_WIDTH = BEAT_SIZE * TAG_WIDTH;
    localparam int OUT_WIDTH      = BEAT_SIZE * DATA_WIDTH;
    localparam int IDX_W          = (TAG_CATAGORY > 1) ? $clog2(TAG_CATAGORY) : 1;
    localparam int CNT_W          = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int SEL_W          = $clog2(TAG_CATAGORY + 1);
    localparam int ERR_W          = TAG_CATAGORY + 1;

    if (DATA_WIDTH % TAG_WIDTH != 0) begin : g_bad_ratio
        $error("DATA_WIDTH must be a multiple of TAG_WIDTH");
    end
    if (FRAME_BEATS < 1 || TAG_CATAGORY < 1) begin : g_bad_size
        $error("FRAME_BEATS and TAG_CATAGORY must be at least 1");
    end

    typedef enum logic {
        ST_PHASE,
        ST_TAG
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [SEL_W-1:0]     sel;
    logic [CNT_W-1:0]     pack_cnt;
    logic [OUT_WIDTH-1:0] pack_reg;
    logic [OUT_WIDTH-1:0] pack_merged;
    logic [OUT_WIDTH-1:0] phase_beat;
    logic                 phase_last;
    logic                 load_ok;
    logic                 phase_hs;
    logic                 tag_hs;
    logic                 pack_full;
    logic                 tag_emit;

    assign sel = (state_q == ST_TAG) ? SEL_W'(TAG_CATAGORY) : SEL_W'(idx_q);

    // Gating with aresetn keeps every tready low while reset is held.
    assign load_ok    = aresetn & (~m_axis_tvalid | m_axis_tready);
    assign phase_beat = s_phase_tdata[idx_q*OUT_WIDTH +: OUT_WIDTH];
    assign phase_last = s_phase_tlast[idx_q];
    assign phase_hs   = (state_q == ST_PHASE) & s_phase_tvalid[idx_q] & load_ok;
    assign tag_hs     = (state_q == ST_TAG) & s_tag_tvalid & load_ok;
    assign pack_full  = (pack_cnt == CNT_W'(PACK - 1));
    assign tag_emit   = tag_hs & (pack_full | s_tag_tlast);

    always_comb begin
        pack_merged = pack_reg;
        for (int j = 0; j < PACK; j++) begin
            if (pack_cnt == CNT_W'(j)) begin
                pack_merged[j*TAG_PART_WIDTH +: TAG_PART_WIDTH] = s_tag_tdata;
            end
        end
    end

    always_comb begin
        s_phase_tready = '0;
        s_tag_tready   = 1'b0;
        if (state_q == ST_PHASE) begin
            s_phase_tready[idx_q] = load_ok;
        end else begin
            s_tag_tready = load_ok;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_PHASE: begin
                if (phase_hs && phase_last) begin
                    if (idx_q == IDX_W'(TAG_CATAGORY - 1)) begin
                        state_d = ST_TAG;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_TAG: begin
                if (tag_hs && s_tag_tlast) begin
                    state_d = ST_PHASE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_PHASE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_PHASE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // A closed group clears the staging register so a short group is zero-padded.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pack_cnt <= '0;
            pack_reg <= '0;
        end else if (tag_hs) begin
            if (tag_emit) begin
                pack_cnt <= '0;
                pack_reg <= '0;
            end else begin
                pack_cnt <= pack_cnt + 1'b1;
                pack_reg <= pack_merged;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (phase_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= phase_beat;
            m_axis_tlast  <= phase_last;
        end else if (tag_emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pack_merged;
            m_axis_tlast  <= s_tag_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef PHASE_SEQ_LEN_CHECK_EN
    localparam int BC_W = $clog2(FRAME_BEATS + 1) + 1;

    logic [BC_W-1:0] beat_cnt;
    logic [BC_W-1:0] beat_nxt;
    logic            frame_hs;
    logic            frame_last;

    assign frame_hs   = phase_hs | tag_hs;
    assign frame_last = phase_hs ? phase_last : s_tag_tlast;
    assign beat_nxt   = beat_cnt + 1'b1;

    // Flags both an early tlast and a frame running past FRAME_BEATS.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt <= '0;
            len_err  <= '0;
        end else if (frame_hs) begin
            beat_cnt <= frame_last ? '0 : beat_nxt;
            if ((beat_nxt == BC_W'(FRAME_BEATS)) ^ frame_last) begin
                len_err <= len_err | (ERR_W'(1) << sel);
            end
        end
    end
`else
    assign len_err = '0;
`endif

endmodule

// File: doc/phase_frame_sequencer.md
Name: phase_frame_sequencer

Overview:
Upstream feeder of the phase-assembly stage. Merges TAG_CATAGORY parallel phase streams and one per-pixel tag stream into a single AXI-Stream frame sequence: phase frame 0, phase frame 1, …, phase frame TAG_CATAGORY-1, then the tag frame.
- Tags are packed PACK = DATA_WIDTH/TAG_WIDTH input beats per output beat.
- The first tag beat of a group occupies the lowest TAG_PART_WIDTH = BEAT_SIZE*TAG_WIDTH bits of the output beat.
- This is the layout the downstream assembly stage indexes.

Parameters:
- DATA_WIDTH, 16, bits per phase sample.
- TAG_WIDTH, 8, bits per tag; DATA_WIDTH must be an integer multiple of TAG_WIDTH.
- TAG_CATAGORY, 4, number of phase streams (>=1).
- BEAT_SIZE, 8, samples/tags per beat.
- FRAME_BEATS, 512, expected beats per input frame; used only by the optional length check.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_phase_tdata  in  TAG_CATAGORY*BEAT_SIZE*DATA_WIDTH  phase stream k in slice k.
- s_phase_tvalid  in  TAG_CATAGORY  per-stream valid.
- s_phase_tready  out  TAG_CATAGORY  per-stream ready.
- s_phase_tlast  in  TAG_CATAGORY  per-stream end of frame.
- s_tag_tdata  in  BEAT_SIZE*TAG_WIDTH  tags, one per pixel.
- s_tag_tvalid  in  1  tag valid.
- s_tag_tready  out  1  tag ready.
- s_tag_tlast  in  1  end of tag frame.
- m_axis_tdata  out  BEAT_SIZE*DATA_WIDTH  merged stream.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of each frame.
- len_err  out  TAG_CATAGORY+1  sticky frame-length error; bit TAG_CATAGORY is the tag frame.

Behaviour:
- Reset (async, aresetn=0): sel=0, pack_cnt=0, pack_reg=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, len_err=0, all treadys 0. Reset asserted mid-frame discards any partial frame and partial pack group; after release, sequencing restarts at phase 0.
- Output register: one stage. load_ok = ~m_axis_tvalid | m_axis_tready. On load, valid=1. On m_axis_tvalid & m_axis_tready with no new load, valid=0. Throughput is 1 beat/cycle; latency is 1 cycle from input handshake to m_axis_tvalid.
- FSM state is sel in 0..TAG_CATAGORY.
- PHASE_k (sel=k<TAG_CATAGORY):
  - s_phase_tready[k]=load_ok; all other phase treadys and s_tag_tready are 0.
  - Each handshake loads slice k and its tlast unchanged.
  - On a handshake with tlast, sel<=k+1.
  - Other streams' tvalid is ignored; they stall.
- TAG (sel=TAG_CATAGORY):
  - s_tag_tready=load_ok.
  - Each handshake writes the input into pack_reg slot pack_cnt, at bits [pack_cnt*TAG_PART_WIDTH +: TAG_PART_WIDTH].
  - If pack_cnt==PACK-1 or s_tag_tlast: load the output with the completed group (current beat merged combinationally), tlast=s_tag_tlast. Then pack_cnt<=0 and pack_reg<=0.
  - Otherwise pack_cnt++ and no output load.
  - On tag tlast, sel<=0 (wrap).
  - A partial last group is zero-padded in the unfilled upper slots.
- PACK=1: the tag path is a straight pass; every beat emits.
- Phase tlast and tag tlast on the same cycle: impossible to conflict, since only the stream selected by sel is ever ready.
- Output beats per full sequence: TAG_CATAGORY*FRAME_BEATS + ceil(FRAME_BEATS/PACK).

Optional Feature:
Macro PHASE_SEQ_LEN_CHECK_EN.
- Defined:
  - A beat counter runs per frame; it resets on tlast.
  - len_err[sel] sets when tlast arrives with count+1 != FRAME_BEATS.
  - len_err[sel] also sets when count+1 == FRAME_BEATS without tlast.
  - Set bits stay set until reset.
  - Data flow is unaffected; frames are still switched only on tlast.
- Not defined: no counter logic; len_err tied to 0.

Test Plan:
1. Defaults, FRAME_BEATS=4, always ready; phase k data=beat index+16*k, tags 0x01..0x04 replicated across lanes.
   -> Output order is 4 beats each of phase 0..3, then 2 tag beats. Tag beat 0 has low 64 bits = 0x01 lanes and high 64 bits = 0x02 lanes. Tlast on output beats 3, 7, 11, 15, 17.
2. Tag frame of 3 beats.
   -> 2 output tag beats; the second has its high half =0 and tlast=1. sel returns to 0.
3. m_axis_tready toggled 1010…, random valids on all inputs.
   -> Output matches scenario 1 exactly. m_axis_tdata is stable while valid & ~ready. No beat dropped or duplicated.
4. Phase 2 and tag streams valid early, during phase 0.
   -> s_phase_tready[2] and s_tag_tready stay 0 until their turn. Ordering is preserved.
5. Assert aresetn low mid-phase-1 and mid-tag-group.
   -> m_axis_tvalid drops immediately. After release, the first output is phase 0 beat 0, with no leftover tag slot.
6. With PHASE_SEQ_LEN_CHECK_EN, FRAME_BEATS=4: phase 1 frame of 3 beats, tag frame of 5 beats.
   -> len_err=5'b10010. Without the macro, len_err=0.
